// File: rtl/chan_byte_arbiter_pkg.sv
// chan_arb_pkg: shared types and helpers for the N-channel byte arbiter.
//   t_byte      - 8-bit byte type (used for the per-channel stall counters)
//   t_arb_state - packet-lock state (ARB_IDLE / ARB_LOCK)
//   STALL_LIMIT - stall count at which the sticky overflow flag fires
//   rr_pick     - round-robin search returning {found, index}
package chan_arb_pkg;

   typedef logic [7:0] t_byte;

   typedef enum logic {ARB_IDLE, ARB_LOCK} t_arb_state;

   localparam int STALL_LIMIT = 255;
   localparam int MAX_CH      = 16;

   // Searches req starting at ptr and wrapping. Request bits above the real
   // channel count are always zero, so a 16-wide wrap visits the same live
   // channels in the same order as a wrap modulo NUM_CH.
   // Result bit 4 is the found flag, bits 3:0 the granted index.
   function automatic logic [4:0] rr_pick(input logic [MAX_CH-1:0] req,
                                          input logic [3:0] ptr);
      logic [4:0] res;
      logic [3:0] idx;
      res = '0;
      // Walk from farthest to nearest so the nearest requester wins.
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         idx = ptr + 4'(k);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

endpackage

// File: rtl/chan_byte_arbiter_fifo.sv
// byte_fifo: small synchronous FIFO holding {last, data} words for one channel.
//   clk, rst_n  - clock, synchronous active-low reset (empties the FIFO)
//   push, pop   - write / read strobes (caller guarantees not full / not empty)
//   din, dout   - write word, current head word (combinational from storage)
//   count       - registered occupancy 0..DEPTH
//   full, empty - decoded from count
module byte_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   // The head is read combinationally: the output register must take the
   // head in the same cycle the arbiter grants, so no read latency is allowed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (push && !pop)      count_reg <= count_reg + CW'(1);
         else if (pop && !push) count_reg <= count_reg - CW'(1);
      end
   end

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/chan_byte_arbiter.sv
// chan_byte_arbiter: NUM_CH per-channel byte FIFOs drained round-robin into
// one registered output stream tagged with the source channel.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - per-channel write handshake
//   in_data, in_last    - per-channel byte and end-of-packet flag
//   out_valid/out_ready - output handshake
//   out_data, out_last  - output byte and its last flag
//   out_chan            - source channel of the output beat
//   ovf_err             - sticky per-channel "stalled while full too long"
// With PKT_MODE=1 a grant is held on one channel until its last beat.
module chan_byte_arbiter
   import chan_arb_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int W        = 8,
   parameter int DEPTH    = 4,
   parameter int PKT_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          in_valid,
   input  logic [NUM_CH*W-1:0]        in_data,
   input  logic [NUM_CH-1:0]          in_last,
   output logic [NUM_CH-1:0]          in_ready,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   output logic                       out_last,
   output logic [$clog2(NUM_CH)-1:0]  out_chan,
   input  logic                       out_ready,
   output logic [NUM_CH-1:0]          ovf_err
);

   localparam int CW    = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [W:0]        head  [NUM_CH];
   logic [CNT_W-1:0]  count [NUM_CH];
   logic [NUM_CH-1:0] push, pop, full, empty;

   logic [MAX_CH-1:0] req;
   logic [4:0]        pick;
   logic              grant_valid;
   logic [CW-1:0]     grant_ch;
   logic [W:0]        head_sel;
   logic              load;

   t_arb_state        state_reg;
   logic [CW-1:0]     lock_ch_reg;
   logic [CW-1:0]     rr_reg;
   logic              out_valid_reg;
   logic [W-1:0]      out_data_reg;
   logic              out_last_reg;
   logic [CW-1:0]     out_chan_reg;

   // Per-channel FIFO, write side and stall monitor.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         t_byte stall_cnt_reg;
         logic  ovf_reg;

         // Ready comes from the registered count only: a full FIFO stays
         // not-ready even in a cycle where it is being popped.
         assign in_ready[gi] = (count[gi] != CNT_W'(DEPTH));
         assign push[gi]     = in_valid[gi] && in_ready[gi];
         assign pop[gi]      = load && grant_valid && (grant_ch == CW'(gi));

         byte_fifo #(
            .W     (W + 1),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .din   ({in_last[gi], in_data[gi*W +: W]}),
            .dout  (head[gi]),
            .count (count[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
         );

         // Counts consecutive stalled cycles; the cycle after the counter
         // has saturated at STALL_LIMIT raises the sticky flag.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               stall_cnt_reg <= '0;
               ovf_reg       <= 1'b0;
            end else if (in_valid[gi] && full[gi]) begin
               if (stall_cnt_reg == t_byte'(STALL_LIMIT)) ovf_reg <= 1'b1;
               else stall_cnt_reg <= stall_cnt_reg + 8'd1;
            end else begin
               stall_cnt_reg <= '0;
            end
         end

         assign ovf_err[gi] = ovf_reg;
      end
   endgenerate

   // While locked, only the locked channel may request.
   always_comb begin
      req = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         req[c] = !empty[c] &&
                  ((state_reg == ARB_IDLE) || (lock_ch_reg == CW'(c)));
      end
   end

   assign pick        = rr_pick(req, 4'(rr_reg));
   assign grant_valid = pick[4];
   assign grant_ch    = CW'(pick[3:0]);
   assign head_sel    = head[grant_ch];
   assign load        = !out_valid_reg || out_ready;

   // Output register, round-robin pointer and packet-lock FSM. Everything
   // here only moves on the load condition, so back-pressure freezes it all.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ARB_IDLE;
         lock_ch_reg   <= '0;
         rr_reg        <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_chan_reg  <= '0;
      end else if (load) begin
         if (grant_valid) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= head_sel[W-1:0];
            out_last_reg  <= head_sel[W];
            out_chan_reg  <= grant_ch;
            rr_reg        <= (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
            if (PKT_MODE != 0) begin
               case (state_reg)
                  ARB_IDLE: begin
                     if (!head_sel[W]) begin
                        state_reg   <= ARB_LOCK;
                        lock_ch_reg <= grant_ch;
                     end
                  end
                  ARB_LOCK: begin
                     if (head_sel[W]) state_reg <= ARB_IDLE;
                  end
                  default: state_reg <= ARB_IDLE;
               endcase
            end
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_chan_byte_arbiter.sv
// Bench for chan_byte_arbiter: one byte-interleave instance (dut0) and one
// packet-lock instance (dut1) share the same input stimulus.
module tb_chan_byte_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic        out_ready;

   logic [3:0]  ir0, ir1, ovf0, ovf1;
   logic        ov0, ov1, ol0, ol1;
   logic [7:0]  od0, od1;
   logic [1:0]  oc0, oc1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic       v;
      logic [1:0] ch;
      logic [7:0] d;
      logic       l;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   chan_byte_arbiter #(.NUM_CH(4), .W(8), .DEPTH(4), .PKT_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(ir0), .out_valid(ov0), .out_data(od0),
      .out_last(ol0), .out_chan(oc0), .out_ready(out_ready), .ovf_err(ovf0));

   chan_byte_arbiter #(.NUM_CH(4), .W(8), .DEPTH(4), .PKT_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(ir1), .out_valid(ov1), .out_data(od1),
      .out_last(ol1), .out_chan(oc1), .out_ready(out_ready), .ovf_err(ovf1));

   function automatic beat_t mk(input logic v, input logic [1:0] ch,
                                input logic [7:0] d, input logic l);
      beat_t b;
      b.v = v; b.ch = ch; b.d = d; b.l = l;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         in_last   = 4'($urandom);
         out_ready = 1'($urandom);
         tick();
         total_cnt++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov0); else pass_cnt++;
         total_cnt++; if (od0 !== 8'h00) $display("FAIL reset_out_data: got %h want 00", od0); else pass_cnt++;
         total_cnt++; if (ol0 !== 1'b0) $display("FAIL reset_out_last: got %b want 0", ol0); else pass_cnt++;
         total_cnt++; if (oc0 !== 2'd0) $display("FAIL reset_out_chan: got %0d want 0", oc0); else pass_cnt++;
         total_cnt++; if (ovf0 !== 4'h0) $display("FAIL reset_ovf_err: got %b want 0000", ovf0); else pass_cnt++;
      end
      rst_n = 1'b1; in_valid = '0; out_ready = 1'b0;
      total_cnt++; if (ir0 !== 4'hF) $display("FAIL reset_in_ready: got %b want 1111", ir0); else pass_cnt++;
      total_cnt++; if (ir1 !== 4'hF) $display("FAIL reset_in_ready_pkt: got %b want 1111", ir1); else pass_cnt++;
      tick();
      total_cnt++; if (ov1 !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", ov1); else pass_cnt++;
      $display("tx reset done");
   endtask

   task automatic test_latency();
      beat_t e;
      do_reset();
      out_ready = 1'b1;
      in_valid  = 4'b0100;
      in_data   = 32'h00A5_0000;
      in_last   = 4'b0100;
      exp_q.push_back(mk(1'b1, 2'd2, 8'hA5, 1'b1));
      tick();
      in_valid = '0;
      total_cnt++; if (ov0 !== 1'b0) $display("FAIL latency_early: got valid %b want 0", ov0); else pass_cnt++;
      tick();
      e = exp_q.pop_front();
      $display("tx latency ch=%0d data=%02h last=%b", oc0, od0, ol0);
      total_cnt++; if (ov0 !== e.v) $display("FAIL latency_valid: got %b want %b", ov0, e.v); else pass_cnt++;
      total_cnt++; if (od0 !== e.d) $display("FAIL latency_data: got %h want %h", od0, e.d); else pass_cnt++;
      total_cnt++; if (oc0 !== e.ch) $display("FAIL latency_chan: got %0d want %0d", oc0, e.ch); else pass_cnt++;
      total_cnt++; if (ol0 !== e.l) $display("FAIL latency_last: got %b want %b", ol0, e.l); else pass_cnt++;
      tick();
      total_cnt++; if (ov0 !== 1'b0) $display("FAIL latency_drain: got valid %b want 0", ov0); else pass_cnt++;
   endtask

   task automatic test_fairness();
      beat_t e;
      do_reset();
      out_ready = 1'b1;
      in_valid  = 4'hF;
      in_data   = 32'h1312_1110;
      in_last   = 4'hF;
      for (int k = 0; k < 32; k++) exp_q.push_back(mk(1'b1, 2'(k % 4), 8'(8'h10 + k % 4), 1'b1));
      tick();
      total_cnt++; if (ov0 !== 1'b0) $display("FAIL fair_first_edge: got valid %b want 0", ov0); else pass_cnt++;
      for (int k = 0; k < 32; k++) begin
         tick();
         e = exp_q.pop_front();
         $display("tx fair ch=%0d data=%02h valid=%b", oc0, od0, ov0);
         total_cnt++; if (ov0 !== 1'b1) $display("FAIL fair_gap: beat %0d got valid %b want 1", k, ov0); else pass_cnt++;
         total_cnt++; if (oc0 !== e.ch) $display("FAIL fair_chan: beat %0d got %0d want %0d", k, oc0, e.ch); else pass_cnt++;
         total_cnt++; if (od0 !== e.d) $display("FAIL fair_data: beat %0d got %h want %h", k, od0, e.d); else pass_cnt++;
      end
      in_valid = '0;
   endtask

   task automatic test_packet_lock();
      beat_t e;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = '0; in_data = '0; in_last = '0;
         case (i)
            0: begin in_valid = 4'b0010; in_data = 32'h0000_5100; in_last = 4'b0000;
                     exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 1'b0)); end
            1: begin in_valid = 4'b1001; in_data = 32'h0300_0001; in_last = 4'b1001;
                     exp_q.push_back(mk(1'b1, 2'd1, 8'h51, 1'b0)); end
            2: begin in_valid = 4'b0010; in_data = 32'h0000_5200; in_last = 4'b0000;
                     exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 1'b0)); end
            3: begin in_valid = 4'b0010; in_data = 32'h0000_5300; in_last = 4'b0010;
                     exp_q.push_back(mk(1'b1, 2'd1, 8'h52, 1'b0)); end
            4: exp_q.push_back(mk(1'b1, 2'd1, 8'h53, 1'b1));
            5: exp_q.push_back(mk(1'b1, 2'd3, 8'h03, 1'b1));
            6: exp_q.push_back(mk(1'b1, 2'd0, 8'h01, 1'b1));
            default: exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 1'b0));
         endcase
         tick();
         e = exp_q.pop_front();
         $display("tx pkt cyc=%0d valid=%b ch=%0d data=%02h last=%b", i, ov1, oc1, od1, ol1);
         total_cnt++; if (ov1 !== e.v) $display("FAIL pkt_valid: cyc %0d got %b want %b", i, ov1, e.v); else pass_cnt++;
         if (e.v) begin
            total_cnt++; if (oc1 !== e.ch) $display("FAIL pkt_chan: cyc %0d got %0d want %0d", i, oc1, e.ch); else pass_cnt++;
            total_cnt++; if (od1 !== e.d) $display("FAIL pkt_data: cyc %0d got %h want %h", i, od1, e.d); else pass_cnt++;
            total_cnt++; if (ol1 !== e.l) $display("FAIL pkt_last: cyc %0d got %b want %b", i, ol1, e.l); else pass_cnt++;
         end
      end
      in_valid = '0;
   endtask

   task automatic test_back_to_back();
      beat_t e;
      int sent, got;
      logic acc, ld;
      do_reset();
      sent = 0; got = 0;
      in_last = 4'hF;
      for (int i = 0; i < 50; i++) begin
         out_ready = (i >= 20);
         if (sent < 6) begin
            in_valid = 4'b0001;
            in_data  = {24'h0, 8'(8'h30 + sent)};
         end else begin
            in_valid = '0;
         end
         acc = in_valid[0] && ir0[0];
         ld  = !ov0 || out_ready;
         tick();
         if (acc) begin
            exp_q.push_back(mk(1'b1, 2'd0, 8'(8'h30 + sent), 1'b1));
            sent++;
         end
         if (ld && ov0) begin
            got++;
            $display("tx b2b ch=%0d data=%02h", oc0, od0);
            if (exp_q.size() == 0) begin
               total_cnt++; $display("FAIL b2b_extra: got beat %h want none", od0);
            end else begin
               e = exp_q.pop_front();
               total_cnt++; if (od0 !== e.d) $display("FAIL b2b_data: got %h want %h", od0, e.d); else pass_cnt++;
               total_cnt++; if (oc0 !== e.ch) $display("FAIL b2b_chan: got %0d want %0d", oc0, e.ch); else pass_cnt++;
            end
         end
         if (i == 10 || i == 19) begin
            total_cnt++; if (ir0[0] !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", ir0[0]); else pass_cnt++;
            total_cnt++; if (sent != 5) $display("FAIL b2b_accepted: got %0d want 5", sent); else pass_cnt++;
            total_cnt++; if (ov0 !== 1'b1 || od0 !== 8'h30) $display("FAIL b2b_hold: got %b/%h want 1/30", ov0, od0); else pass_cnt++;
         end
      end
      in_valid = '0;
      total_cnt++; if (got != 6) $display("FAIL b2b_count: got %0d want 6", got); else pass_cnt++;
      total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_lost: got %0d pending want 0", exp_q.size()); else pass_cnt++;
   endtask

   task automatic test_stall();
      int stalls;
      logic st;
      do_reset();
      stalls    = 0;
      in_valid  = 4'b0010;
      in_data   = 32'h0000_7700;
      in_last   = 4'hF;
      for (int i = 0; i < 400 && stalls < 260; i++) begin
         st = in_valid[1] && !ir0[1];
         tick();
         if (st) begin
            stalls++;
            if (stalls == 255) begin
               total_cnt++; if (ovf0[1] !== 1'b0) $display("FAIL stall_early: got %b want 0", ovf0[1]); else pass_cnt++;
            end
            if (stalls == 256) begin
               total_cnt++; if (ovf0[1] !== 1'b1) $display("FAIL stall_set: got %b want 1", ovf0[1]); else pass_cnt++;
            end
         end
      end
      $display("tx stall cycles=%0d ovf=%b", stalls, ovf0);
      total_cnt++; if (stalls != 260) $display("FAIL stall_timeout: got %0d stalls want 260", stalls); else pass_cnt++;
      in_valid  = '0;
      out_ready = 1'b1;
      repeat (10) tick();
      total_cnt++; if (ovf0 !== 4'b0010) $display("FAIL stall_sticky: got %b want 0010", ovf0); else pass_cnt++;
      total_cnt++; if (ovf1 !== 4'b0010) $display("FAIL stall_sticky_pkt: got %b want 0010", ovf1); else pass_cnt++;
      do_reset();
      total_cnt++; if (ovf0 !== 4'b0000) $display("FAIL stall_reset: got %b want 0000", ovf0); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fairness();
      test_packet_lock();
      test_back_to_back();
      test_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/chan_byte_arbiter.md
# chan_byte_arbiter

Parametrised N-channel byte arbiter: each channel feeds bytes into a private FIFO through a valid/ready handshake. A round-robin arbiter drains the FIFOs into one registered output stream, tagged with the source channel. The block is the multi-channel successor of the single-pair `one`/`two` interface endpoints. It sits between per-channel producers and a shared downstream byte consumer, and adds buffering, fairness and an optional packet-lock mode.

## Interface
- `NUM_CH`, 4: channel count, 2..16.
- `W`, 8: data width in bits.
- `DEPTH`, 4: per-channel FIFO depth, power of two, ≥2.
- `PKT_MODE`, 0: 0 = byte interleave; 1 = grant held until `last` beat.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  NUM_CH  per-channel byte valid.
- `in_data`  in  NUM_CH×W  per-channel byte.
- `in_last`  in  NUM_CH  per-channel end-of-packet marker.
- `in_ready`  out  NUM_CH  per-channel FIFO not full.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  W  output byte.
- `out_last`  out  1  `last` flag carried with the byte.
- `out_chan`  out  $clog2(NUM_CH)  source channel of the beat.
- `out_ready`  in  1  downstream accept.
- `ovf_err`  out  NUM_CH  sticky: `in_valid` asserted while full for >255 consecutive cycles.

## Operation
- **Write:** channel c pushes `{in_last, in_data}` when `in_valid[c] && in_ready[c]`.
- **`in_ready`:** `in_ready[c] = (count[c] != DEPTH)`, taken from the registered count. There is no same-cycle bypass, so a full FIFO stays not-ready even in a cycle where it pops.
- **Output register:** loads whenever `!out_valid || out_ready` (the "load condition"). It loads the head of the granted FIFO if a grant exists; otherwise `out_valid` goes 0.
- **Round-robin:**
  - The pointer `rr` resets to 0.
  - The arbiter searches channels `rr, rr+1, …` (mod NUM_CH) for the first non-empty FIFO.
  - After a grant to channel g is loaded, `rr` = g+1 (mod NUM_CH).
- **PKT_MODE=1 state machine (two states):**
  - IDLE → LOCK(g): on loading a beat from g with `last=0`.
  - LOCK(g): only g is eligible. If FIFO g is empty, `out_valid` drops and no other channel is served.
  - LOCK(g) → IDLE: on loading g's beat with `last=1`, and `rr` advances to g+1.
  - PKT_MODE=0: permanently IDLE, and `last` is passed through only.
- **Counts:** `count[c]` increments on push, decrements on pop, and is unchanged on simultaneous push+pop. Pointers wrap modulo DEPTH, with width $clog2(DEPTH).
- **`ovf_err[c]`:** an 8-bit saturating stall counter.
  - It increments while `in_valid[c] && !in_ready[c]` and clears otherwise.
  - At 255 it sets the sticky bit, which is cleared only by reset.
- **Reset mid-operation:** all FIFOs are emptied, partially transferred packets are discarded, the lock is released, and `rr`=0.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `out_chan`=0, `in_ready`=all 1 on the first cycle after reset release, `ovf_err`=0.
- **Latency:** a byte written at edge t into an empty FIFO of an idle block appears with `out_valid`=1 after edge t+1, i.e. 2 cycles input to output.
- **Throughput:** 1 beat/cycle sustained with `out_ready`=1.
- **Back-pressure:** while `out_valid && !out_ready`, `out_data`/`out_last`/`out_chan` are held stable, `rr` and the lock state are frozen, and no FIFO pops.
- **Pop timing:** a FIFO pops in the same cycle the output register loads its head.

## Structure
- Package `chan_arb_pkg`:
  - `t_byte` (logic[7:0]);
  - state enum `t_arb_state` {ARB_IDLE, ARB_LOCK};
  - constant `STALL_LIMIT` = 255;
  - function `rr_pick(req, ptr)` returning the next granted index.
- Sub-module `byte_fifo` (parameters W+1 and DEPTH; ports push, pop, data in/out, count, full, empty), instantiated NUM_CH times via generate.
- Top level: arbiter, lock FSM, output register, stall counters.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with random inputs → all outputs at reset values, `in_ready`=all 1 after release.
- **Single-channel latency:** ch2 writes 0xA5 at cycle 10, `out_ready`=1 → `out_valid`=1, `out_data`=0xA5, `out_chan`=2 at cycle 12.
- **Fairness:** PKT_MODE=0, all 4 channels continuously valid with bytes 0x10+c → `out_chan` sequence 0,1,2,3,0,1,… with no gaps.
- **Packet lock:** PKT_MODE=1, ch1 sends a 3-beat packet (`last` on beat 3) while ch0/ch3 are valid → 3 consecutive beats with `out_chan`=1, then ch3, then ch0.
- **Full/back-pressure:** `out_ready`=0 with ch0 writing 6 bytes at DEPTH=4 → `in_ready[0]`=0 after 4 pushes plus 1 byte in the output register. Release `out_ready` → bytes emerge in order, none lost or duplicated.
- **Stall error:** ch1 is full and `in_valid[1]` is held for 256 cycles → `ovf_err[1]`=1, and it remains 1 until reset.
